key_debounce_multi: RTL and testbench

//   Parametrised, multi-channel successor to the single-input key debouncer used on board keys and reset buttons.
//   Per channel: 2-FF synchroniser, polarity normalisation, debounce counter, debounced level, one-cycle press/release pulses.

---
 rtl/key_debounce_multi.sv | 73 +++++++
 tb/tb_key_debounce_multi.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel sync, polarity normalise, debounce, press/release pulses; long press under KEY_DEBOUNCE_LONG_PRESS_EN.
// The release pulse port is named release_pulse because release is a reserved word.
module key_debounce_multi #(
    parameter int CH           = 3,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int ACTIVE_LOW   = 1,
    parameter int LONG_CYC     = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] key_in,
    output logic [CH-1:0] level,
    output logic [CH-1:0] press,
    output logic [CH-1:0] release_pulse,
    output logic [CH-1:0] long_press,
    output logic          any_pressed
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CH-1:0] IDLE = {CH{ACTIVE_LOW != 0}};
    logic [CH-1:0] s1, s2, p, lvl_n;
    assign p = s2 ^ IDLE;
    assign any_pressed = |level;
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [DW-1:0] dcnt;
        logic          hit;
        assign hit = (p[c] != level[c]) && (dcnt == DW'(DEBOUNCE_CYC - 1));
        assign lvl_n[c] = level[c] ^ hit;
        always_ff @(posedge clk) begin
            if (rst)
                dcnt <= '0;
            else
                dcnt <= (p[c] == level[c] || hit) ? '0 : dcnt + DW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1            <= IDLE;
            s2            <= IDLE;
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
        end else begin
            s1            <= key_in;
            s2            <= s1;
            level         <= lvl_n;
            press         <= lvl_n & ~level;
            release_pulse <= level & ~lvl_n;
        end
    end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYC + 1);
    logic [CH-1:0] lp_n;
    for (genvar c = 0; c < CH; c++) begin : g_hold
        logic [HW-1:0] hcnt;
        // suppressed on the accepting-release edge so it never coincides with release
        assign lp_n[c] = level[c] && lvl_n[c] && (hcnt == HW'(LONG_CYC - 1));
        always_ff @(posedge clk) begin
            if (rst)
                hcnt <= '0;
            else
                hcnt <= !level[c] ? '0 : (hcnt == HW'(LONG_CYC)) ? hcnt : hcnt + HW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            long_press <= '0;
        else
            long_press <= lp_n;
    end
`else
    assign long_press = '0;
`endif
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: directed checks of debounce latency, glitch rejection, pulses, long press and reset.
module tb_key_debounce_multi;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_in = 3'b111;
    logic [2:0] level, press, release_pulse, long_press;
    logic       any_pressed;
    int checks = 0;
    int errors = 0;

    key_debounce_multi #(
        .CH(3), .DEBOUNCE_CYC(4), .ACTIVE_LOW(1), .LONG_CYC(10)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .level(level), .press(press),
        .release_pulse(release_pulse), .long_press(long_press), .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key_in = 3'b111;
        for (int k = 1; k <= 23; k++) begin
            if (k == 4) rst = 1'b0;
            step();
            checks++;
            if ({level, press, release_pulse, long_press, any_pressed} !== 13'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got %b want 0", k, {level, press, release_pulse, long_press, any_pressed});
            end
        end
    endtask

    task automatic test_press_release;
        key_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if ({press[0], level[0], release_pulse[0], any_pressed} !== {k == 6, k >= 6, 1'b0, k >= 6}) begin
                errors++;
                $display("FAIL press k=%0d got %b want %b", k, {press[0], level[0], release_pulse[0], any_pressed}, {k == 6, k >= 6, 1'b0, k >= 6});
            end
        end
        key_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if ({press[0], level[0], release_pulse[0], any_pressed} !== {1'b0, k < 6, k == 6, k < 6}) begin
                errors++;
                $display("FAIL release k=%0d got %b want %b", k, {press[0], level[0], release_pulse[0], any_pressed}, {1'b0, k < 6, k == 6, k < 6});
            end
        end
    endtask

    task automatic test_glitch;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 6; k++) begin
                key_in[1] = (k >= 3);
                step();
                checks++;
                if ({press[1], level[1], release_pulse[1]} !== 3'b000) begin
                    errors++;
                    $display("FAIL glitch r=%0d k=%0d got %b want 000", r, k, {press[1], level[1], release_pulse[1]});
                end
            end
        end
    endtask

    task automatic test_simultaneous;
        key_in[2] = 1'b0;
        repeat (8) step();
        checks++;
        if (level[2] !== 1'b1) begin
            errors++;
            $display("FAIL sim_prep got %b want 1", level[2]);
        end
        key_in[0] = 1'b0;
        key_in[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if ({press[0], release_pulse[2], level[0], level[2], release_pulse[0], press[2]} !==
                {k == 6, k == 6, k >= 6, k < 6, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL simultaneous k=%0d got %b want %b", k,
                         {press[0], release_pulse[2], level[0], level[2], release_pulse[0], press[2]},
                         {k == 6, k == 6, k >= 6, k < 6, 1'b0, 1'b0});
            end
        end
        key_in[0] = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_long_press;
        key_in[0] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            checks++;
            if ({long_press, press[0]} !== {2'b00, LP_EN && k == 16, k == 6}) begin
                errors++;
                $display("FAIL long_press k=%0d got %b want %b", k, {long_press, press[0]}, {2'b00, LP_EN && k == 16, k == 6});
            end
        end
        key_in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if ({long_press[0], release_pulse[0]} !== {1'b0, k == 6}) begin
                errors++;
                $display("FAIL long_release k=%0d got %b want %b", k, {long_press[0], release_pulse[0]}, {1'b0, k == 6});
            end
        end
    endtask

    task automatic test_reset_mid_count;
        key_in[0] = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({level, press, any_pressed} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset got %b want 0", {level, press, any_pressed});
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if ({press[0], level[0]} !== {k == 6, k >= 6}) begin
                errors++;
                $display("FAIL mid_reset_press k=%0d got %b want %b", k, {press[0], level[0]}, {k == 6, k >= 6});
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_long_press();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
